// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int INSTR_W    = 32;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register with flush; one-cycle registered latency.
// Holds instr/pc stable while valid and not ready; flush clears valid and wins over a load.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               fetch,
  input  logic [INSTR_W-1:0] fetch_instr,
  input  logic [31:0]        fetch_pc,
  input  logic               out_ready,
  output logic               can_load,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc
);

  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (can_load) begin
      out_valid <= fetch;
      if (fetch) begin
        out_instr <= fetch_instr;
        out_pc    <= fetch_pc;
      end
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Boot-loads the instruction memory from a loader stream, then fetches sequentially with redirects.
// Fetch latency one cycle, one instr/cycle under out_ready; halts when pc leaves the memory range.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 40,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  input  logic [31:0]        load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic [31:0]        mem_addr,
  output logic               mem_we,
  output logic [31:0]        mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic               halted
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t          state;
  logic [CW-1:0]   load_cnt;
  logic [31:0]     pc;
  logic            in_range;
  logic            redirect;
  logic            fetch;
  logic            can_load;

  assign in_range = (pc >> 2) < DEPTH_W;
  assign redirect = (state != LOAD) && redirect_valid;
  assign fetch    = (state == RUN) && in_range && !redirect;

  // Strobes are gated by rst_n so nothing is accepted or written during reset.
  assign load_ready = rst_n && (state == LOAD);
  assign mem_we     = load_ready && load_valid;
  assign mem_wdata  = load_data;
  assign mem_addr   = (state == LOAD) ? (32'(load_cnt) << 2) : pc;
  assign halted     = rst_n && (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_cnt <= '0;
      pc       <= RESET_PC;
    end else begin
      case (state)
        LOAD: begin
          if (load_valid) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_last || load_cnt == CW'(DEPTH - 1)) begin
              state <= RUN;
              pc    <= RESET_PC;
            end
          end
        end
        RUN, HALT: begin
          if (redirect_valid) begin
            state <= RUN;
            pc    <= word_align(redirect_pc);
          end else if (state == RUN && can_load) begin
            // Wrapped pcs land far above DEPTH and are caught here too.
            if (in_range) pc <= pc + 32'(WORD_BYTES);
            else          state <= HALT;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  fetch_out_reg u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect),
    .fetch       (fetch),
    .fetch_instr (mem_rdata),
    .fetch_pc    (pc),
    .out_ready   (out_ready),
    .can_load    (can_load),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized bench for imem_fetch_ctrl against a behavioural fetch model and an external memory.
module tb_imem_fetch_ctrl;

  localparam int          DEPTH    = 12;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_last      (load_last),
    .load_ready     (load_ready),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External instruction memory, driven only by the DUT's write port.
  logic [31:0] tb_mem [16];
  always @(posedge clk)
    if (mem_we && mem_addr[31:2] < 30'(DEPTH)) tb_mem[mem_addr[5:2]] <= mem_wdata;
  assign mem_rdata = (mem_addr[31:2] < 30'(DEPTH)) ? tb_mem[mem_addr[5:2]] : 32'h0;

  // Reference model state.
  bit          m_load, m_halt, m_ov;
  int          m_cnt;
  logic [31:0] m_pc, m_oi, m_op;
  logic [31:0] m_mem [DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_load = 1; m_halt = 0; m_cnt = 0; m_pc = RESET_PC;
    m_ov = 0; m_oi = 0; m_op = 0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, then move past the edge.
  task automatic step();
    @(negedge clk);
    chk("load_ready", 32'(load_ready), 32'(rst_n && m_load));
    chk("mem_we", 32'(mem_we), 32'(rst_n && m_load && load_valid));
    if (rst_n && m_load && load_valid) begin
      chk("mem_addr_wr", mem_addr, 32'(m_cnt * 4));
      chk("mem_wdata", mem_wdata, load_data);
    end
    if (!m_load) chk("mem_addr_fetch", mem_addr, m_pc);
    chk("halted", 32'(halted), 32'(rst_n && m_halt));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_instr", out_instr, m_oi);
    chk("out_pc", out_pc, m_op);

    if (!rst_n) begin
      model_reset();
    end else if (m_load) begin
      if (load_valid) begin
        m_mem[m_cnt] = load_data;
        if (load_last || m_cnt == DEPTH - 1) begin
          m_load = 0;
          m_pc   = RESET_PC;
        end
        m_cnt++;
      end
    end else if (redirect_valid) begin
      m_ov   = 0;
      m_halt = 0;
      m_pc   = redirect_pc & ~32'h3;
    end else if (!m_ov || out_ready) begin
      if (!m_halt && (m_pc >> 2) < DEPTH) begin
        m_ov = 1;
        m_oi = m_mem[m_pc >> 2];
        m_op = m_pc;
        m_pc = m_pc + 32'd4;
      end else begin
        m_ov   = 0;
        m_halt = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      load_valid = 1'($urandom_range(1));
      load_data  = $urandom;
      step();
    end
    rst_n = 1'b1;
    load_valid = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] data, input logic last);
    if ($urandom_range(3) == 0) begin
      load_valid = 1'b0;
      step();
    end
    load_valid     = 1'b1;
    load_data      = data;
    load_last      = last;
    redirect_valid = ($urandom_range(3) == 0);
    redirect_pc    = $urandom;
    out_ready      = 1'($urandom_range(1));
    step();
    load_valid     = 1'b0;
    load_last      = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic load_prog(input int n, input bit use_last, input int extra);
    for (int i = 0; i < n + extra; i++) load_word($urandom, use_last && (i == n - 1));
  endtask

  task automatic run_cycles(input int n, input int ready_pct, input int redir_pct, input int rst_pct);
    for (int i = 0; i < n; i++) begin
      out_ready      = ($urandom_range(99) < ready_pct);
      redirect_valid = ($urandom_range(99) < redir_pct);
      case ($urandom_range(3))
        0:       redirect_pc = $urandom_range(DEPTH * 4 + 3);
        1:       redirect_pc = 32'(DEPTH * 4 - 8) + $urandom_range(7);
        2:       redirect_pc = $urandom;
        default: redirect_pc = 32'hFFFF_FFFC + $urandom_range(3);
      endcase
      rst_n = !($urandom_range(99) < rst_pct);
      step();
      rst_n = 1'b1;
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0003;
    prog[2] = 32'h0109_5020;

    for (int i = 0; i < 16; i++) tb_mem[i] = 32'h0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    rst_n = 1'b0; load_valid = 1'b0; load_data = 32'h0; load_last = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    do_reset(2);

    // Short program, drained with out_ready held high through to HALT.
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 2);
      step();
    end
    load_valid = 1'b0; load_last = 1'b0;
    run_cycles(DEPTH + 4, 100, 0, 0);

    // Stall with the output held, then redirect from HALT.
    run_cycles(8, 0, 0, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    step();
    redirect_valid = 1'b0;
    run_cycles(4, 100, 0, 0);
    run_cycles(4, 0, 0, 0);
    redirect_valid = 1'b1; redirect_pc = 32'hE;
    step();
    redirect_valid = 1'b0;
    run_cycles(6, 100, 0, 0);

    // Reset in the middle of a load, then reload from address 0.
    do_reset(1);
    load_prog(2, 1'b0, 0);
    do_reset(1);
    load_prog(5, 1'b1, 2);
    run_cycles(30, 70, 5, 0);

    for (int ep = 0; ep < 30; ep++) begin
      do_reset(1 + $urandom_range(1));
      if ($urandom_range(3) == 0) begin
        load_prog(1 + $urandom_range(3), 1'b0, 0);
        do_reset(1);
      end
      load_prog(1 + $urandom_range(DEPTH + 1), 1'($urandom_range(1)), $urandom_range(2));
      case (ep % 3)
        0:       run_cycles(60, 100, 4, 1);
        1:       run_cycles(60, 50, 6, 1);
        default: run_cycles(60, 85, 3, 0);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
